// File: rtl/ws2812_rx_decoder_if.sv
// Signal bundle between a WS2812 line source and the receive decoder.
// The master drives the serial line; the slave returns the decoded word, strobes and relayed line.
interface ws2812_rx_decoder_if;
    logic        din;
    logic [23:0] color_out;
    logic        color_valid;
    logic        frame_err;
    logic        dout;

    modport master (
        output din,
        input  color_out, color_valid, frame_err, dout
    );

    modport slave (
        input  din,
        output color_out, color_valid, frame_err, dout
    );
endinterface

// File: rtl/ws2812_rx_decoder.sv
// WS2812 receive pixel: decodes the first 24 bits after a reset gap into a GRB word
// and relays the rest of the frame on dout, delayed by three cycles.
module ws2812_rx_decoder #(
    parameter int BIT_THRESH   = 32,
    parameter int MIN_HIGH     = 5,
    parameter int MAX_HIGH     = 100,
    parameter int RESET_CYCLES = 2500
) (
    input  logic               clk,
    input  logic               rst,
    ws2812_rx_decoder_if.slave bus
);

    // state   | meaning
    // UNSYNC  | waiting for a clean reset gap
    // READY   | gap seen, waiting for the first bit
    // HIGH    | measuring a high pulse
    // LOW     | between bits of the word
    // FORWARD | word complete, relaying line to dout
    localparam logic [2:0] S_UNSYNC  = 3'd0;
    localparam logic [2:0] S_READY   = 3'd1;
    localparam logic [2:0] S_HIGH    = 3'd2;
    localparam logic [2:0] S_LOW     = 3'd3;
    localparam logic [2:0] S_FORWARD = 3'd4;

    localparam logic [7:0]  L_THRESH   = 8'(BIT_THRESH);
    localparam logic [7:0]  L_MIN_HIGH = 8'(MIN_HIGH);
    localparam logic [7:0]  L_MAX_HIGH = 8'(MAX_HIGH);
    localparam logic [11:0] L_RESET    = 12'(RESET_CYCLES);

    logic [2:0]  r_state;
    logic        r_sync1;
    logic        r_din_s;
    logic        r_din_d;
    logic [7:0]  r_high_cnt;
    logic [11:0] r_low_cnt;
    logic [4:0]  r_bit_cnt;
    logic [22:0] r_shreg;
    logic [23:0] r_color;
    logic        r_valid;
    logic        r_err;
    logic        r_dout;

    logic        w_rise;
    logic        w_fall;
    logic        w_gap;
    logic        w_bit;
    logic [23:0] w_word;

    assign w_rise = r_din_s & ~r_din_d;
    assign w_fall = ~r_din_s & r_din_d;
    assign w_gap  = (r_low_cnt == L_RESET);
    assign w_bit  = (r_high_cnt >= L_THRESH);
    // Only the 23 earlier bits are stored; the final bit joins them as the word is loaded.
    assign w_word = {r_shreg, w_bit};

    assign bus.color_out   = r_color;
    assign bus.color_valid = r_valid;
    assign bus.frame_err   = r_err;
    assign bus.dout        = r_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_UNSYNC;
            r_sync1    <= 1'b0;
            r_din_s    <= 1'b0;
            r_din_d    <= 1'b0;
            r_high_cnt <= 8'd0;
            r_low_cnt  <= 12'd0;
            r_bit_cnt  <= 5'd0;
            r_shreg    <= 23'd0;
            r_color    <= 24'd0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_dout     <= 1'b0;
        end else begin
            r_sync1 <= bus.din;
            r_din_s <= r_sync1;
            r_din_d <= r_din_s;

            if (r_din_s) begin
                r_low_cnt <= 12'd0;
                if (r_high_cnt != L_MAX_HIGH)
                    r_high_cnt <= r_high_cnt + 8'd1;
            end else begin
                r_high_cnt <= 8'd0;
                if (r_low_cnt != L_RESET)
                    r_low_cnt <= r_low_cnt + 12'd1;
            end

            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_dout  <= 1'b0;

            case (r_state)
                S_UNSYNC: begin
                    if (w_gap)
                        r_state <= S_READY;
                end
                S_READY: begin
                    r_bit_cnt <= 5'd0;
                    if (w_rise)
                        r_state <= S_HIGH;
                end
                S_HIGH: begin
                    if (w_fall) begin
                        if (r_high_cnt < L_MIN_HIGH) begin
                            r_err   <= 1'b1;
                            r_state <= S_UNSYNC;
                        end else if (r_bit_cnt == 5'd23) begin
                            r_color <= w_word;
                            r_valid <= 1'b1;
                            r_state <= S_FORWARD;
                        end else begin
                            r_shreg   <= w_word[22:0];
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            r_state   <= S_LOW;
                        end
                    end else if (r_din_s && (r_high_cnt == L_MAX_HIGH)) begin
                        r_err   <= 1'b1;
                        r_state <= S_UNSYNC;
                    end
                end
                S_LOW: begin
                    // A low long enough to be a reset gap wins over a coincident rising edge.
                    if (w_gap) begin
                        r_err   <= 1'b1;
                        r_state <= S_READY;
                    end else if (w_rise) begin
                        r_state <= S_HIGH;
                    end
                end
                S_FORWARD: begin
                    if (w_gap)
                        r_state <= S_READY;
                    else
                        r_dout <= r_din_s;
                end
                default: r_state <= S_UNSYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Scoreboard bench for ws2812_rx_decoder: stimulus pushes expected events, a monitor pops and compares.
module tb_ws2812_rx_decoder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    ws2812_rx_decoder_if bus();

    ws2812_rx_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    // expected event: bit 24 set = frame error, else colour word in [23:0]
    logic [24:0] exp_ev[$];
    int          exp_fwd[$];
    logic [23:0] last_color = 24'd0;
    int          wbuf[64];
    int          nb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Line level v held for n clock samples; always starts and ends 2 ns after a rising edge.
    task automatic drive(input logic v, input int n);
        bus.din = v;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic fill_word(input logic [23:0] word, input int total);
        nb = total;
        for (int i = 0; i < total; i++)
            wbuf[i] = (i < 24 && !word[23 - i]) ? 22 : ((i >= 24 && ($urandom_range(0, 1) == 0)) ? 22 : 42);
    endtask

    task automatic fill_random(input int total);
        nb = total;
        for (int i = 0; i < total; i++)
            wbuf[i] = $urandom_range(5, 100);
    endtask

    // Reference model: a pulse decodes as 1 when its width reaches 32; the first 24 form the word.
    task automatic run_frame(input bit synced);
        logic [23:0] word;
        word = 24'd0;
        if (synced && nb >= 24) begin
            for (int i = 0; i < 24; i++)
                if (wbuf[i] >= 32) word = word | (24'd1 << (23 - i));
            exp_ev.push_back({1'b0, word});
            last_color = word;
            for (int i = 24; i < nb; i++)
                exp_fwd.push_back(wbuf[i]);
        end
        for (int i = 0; i < nb; i++) begin
            drive(1'b1, wbuf[i]);
            drive(1'b0, (wbuf[i] < 52) ? 64 - wbuf[i] : 12);
        end
    endtask

    task automatic gap(input int n);
        drive(1'b0, n);
    endtask

    logic [7:0] h = 8'd0;
    logic       prev_dout = 1'b0;
    int         dout_w = 0;

    initial begin
        forever begin
            @(negedge clk);
            h = {h[6:0], bus.din};
            if (bus.color_valid && bus.frame_err) begin
                n_tests++; n_fail++;
                $display("[TB] FAIL exclusive: color_valid and frame_err both 1, expected not both");
            end else if (bus.color_valid || bus.frame_err) begin
                if (exp_ev.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("[TB] FAIL unexpected_event: valid=%0b err=%0b color=%0h, expected none",
                             bus.color_valid, bus.frame_err, bus.color_out);
                end else begin
                    check("event", bus.frame_err ? {7'd0, 1'b1, 24'd0} : {8'd0, bus.color_out},
                          {7'd0, exp_ev.pop_front()});
                    if (bus.color_valid)
                        check("cv_latency", {30'd0, h[4], h[3]}, 32'd2);
                end
            end
            if (bus.dout !== prev_dout)
                check("dout_lag", {30'd0, h[4], h[3]}, {30'd0, prev_dout, bus.dout});
            if (bus.dout === 1'b1) begin
                dout_w++;
            end else if (dout_w > 0) begin
                if (exp_fwd.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("[TB] FAIL unexpected_dout_pulse: width %0d, expected none", dout_w);
                end else begin
                    check("fwd_width", dout_w, exp_fwd.pop_front());
                end
                dout_w = 0;
            end
            prev_dout = bus.dout;
        end
    end

    initial begin
        bus.din = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_color", {8'd0, bus.color_out}, 32'd0);
        check("rst_valid", {31'd0, bus.color_valid}, 32'd0);
        check("rst_err", {31'd0, bus.frame_err}, 32'd0);
        check("rst_dout", {31'd0, bus.dout}, 32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        gap(2550);

        fill_word(24'hFF0000, 24); run_frame(1'b1); gap(2550);
        fill_word(24'h00A5C3, 48); run_frame(1'b1); gap(2550);
        check("dout_after_gap", {31'd0, bus.dout}, 32'd0);
        fill_word(24'h00FF00, 24); run_frame(1'b1); gap(10000);
        fill_word(24'h0000FF, 24); run_frame(1'b1); gap(2550);

        // glitch mid-frame
        fill_word(24'h5A5A5A, 8); run_frame(1'b1);
        exp_ev.push_back({1'b1, 24'd0});
        drive(1'b1, 3); drive(1'b0, 20);
        check("color_hold_glitch", {8'd0, bus.color_out}, {8'd0, last_color});
        gap(2550);
        fill_word(24'h3C3C3C, 24); run_frame(1'b1); gap(2550);

        // stuck high, then a partial word ended by a reset gap
        exp_ev.push_back({1'b1, 24'd0});
        drive(1'b1, 150); gap(2550);
        fill_word(24'hABCDEF, 12); run_frame(1'b1);
        exp_ev.push_back({1'b1, 24'd0});
        gap(2550);
        check("color_hold_partial", {8'd0, bus.color_out}, {8'd0, last_color});
        fill_word(24'h13579B, 24); run_frame(1'b1); gap(2550);

        // width boundaries: 5 min valid, 31/32 threshold, 100 longest legal
        fill_random(24);
        wbuf[0] = 32; wbuf[1] = 31; wbuf[2] = 5; wbuf[3] = 100; wbuf[23] = 32;
        run_frame(1'b1); gap(2550);

        for (int f = 0; f < 2; f++) begin
            fill_random(24 + $urandom_range(0, 6));
            run_frame(1'b1); gap(2550);
        end

        // reset mid-word, then bits without a gap must not decode
        fill_word(24'hFFFFFF, 11); run_frame(1'b1);
        @(posedge clk); #3 rst = 1'b1; #1;
        last_color = 24'd0;
        check("mid_rst_color", {8'd0, bus.color_out}, 32'd0);
        check("mid_rst_valid", {31'd0, bus.color_valid}, 32'd0);
        check("mid_rst_err", {31'd0, bus.frame_err}, 32'd0);
        check("mid_rst_dout", {31'd0, bus.dout}, 32'd0);
        @(posedge clk); #2 rst = 1'b0;
        fill_word(24'h777777, 24); run_frame(1'b0); gap(2550);
        fill_word(24'h0F1E2D, 24); run_frame(1'b1); gap(100);

        check("pending_events", exp_ev.size(), 32'd0);
        check("pending_fwd", exp_fwd.size(), 32'd0);
        check("final_color", {8'd0, bus.color_out}, {8'd0, last_color});
        check("final_dout", {31'd0, bus.dout}, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
